// File: rtl/phase_gate_gen_pkg.sv
// phase_gate_gen_pkg
//   Shared definitions for the A-to-B phase gate generator and anything that
//   consumes its gate (CLK_count, result-capture stages).
//   - state_t          : measurement FSM encoding (IDLE=0, ARMED=1, GATE=2, DONE=3)
//   - CNT_W_DEFAULT    : default gate counter width, equal to CLK_count's Time width
//   - MAX_GATE_DEFAULT : default gate length limit before timeout
package phase_gate_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_GATE  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CNT_W_DEFAULT    = 16;
    localparam int MAX_GATE_DEFAULT = 65535;

endpackage

// File: rtl/phase_gate_gen_edge_sync.sv
// phase_gate_gen_edge_sync
//   Brings one asynchronous signal into the CLK domain through two flops and
//   adds a third flop for rising-edge detection.
//   Ports:
//     CLK  in  : system clock
//     RST  in  : synchronous active-high reset, clears all three flops
//     sig  in  : asynchronous input
//     rise out : one-cycle pulse per synchronised rising edge
module phase_gate_gen_edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic sig,
    output logic rise
);

    logic sig_p0;
    logic sig_p1;
    logic sig_p2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sig_p0 <= 1'b0;
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            // metastability stages
            sig_p0 <= sig;
            sig_p1 <= sig_p0;
            // edge-detect history
            sig_p2 <= sig_p1;
        end
    end

    assign rise = sig_p1 & ~sig_p2;

endmodule

// File: rtl/phase_gate_gen.sv
// phase_gate_gen
//   Produces the start gate for CLK_count: start is high for exactly the
//   number of clocks between a rising edge of sig_a and the next rising edge
//   of sig_b. One measurement per arm request; a missing B edge ends the gate
//   after MAX_GATE cycles and raises timeout.
//   Ports:
//     CLK     in  : system clock
//     RST     in  : synchronous active-high reset
//     arm     in  : level request for one measurement, sampled in IDLE
//     sig_a   in  : asynchronous reference signal A
//     sig_b   in  : asynchronous measured signal B
//     start   out : gate to CLK_count
//     done    out : one-cycle strobe when a measurement ends
//     timeout out : sticky, last measurement ran out without a B edge
//     busy    out : high while ARMED or in GATE
module phase_gate_gen
    import phase_gate_gen_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int MAX_GATE = MAX_GATE_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic arm,
    input  logic sig_a,
    input  logic sig_b,
    output logic start,
    output logic done,
    output logic timeout,
    output logic busy
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(MAX_GATE - 1);

    state_t           state;
    logic [CNT_W-1:0] gate_cnt;
    logic             a_rise;
    logic             b_rise;

    // Counter value in the final permitted gate cycle.
    function automatic logic gate_expired(input logic [CNT_W-1:0] cnt);
        return cnt == GATE_LAST;
    endfunction

    // Both channels share the same synchroniser depth, so the edge-to-edge
    // distance seen by the FSM equals the distance on the pins.
    phase_gate_gen_edge_sync u_sync_a (
        .CLK  (CLK),
        .RST  (RST),
        .sig  (sig_a),
        .rise (a_rise)
    );

    phase_gate_gen_edge_sync u_sync_b (
        .CLK  (CLK),
        .RST  (RST),
        .sig  (sig_b),
        .rise (b_rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state   <= ST_ARMED;
                        timeout <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    // B alone is ignored; A and B together means zero phase
                    // and the gate never opens.
                    if (a_rise) begin
                        gate_cnt <= '0;
                        if (b_rise) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_GATE;
                        end
                    end
                end
                ST_GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    // A B edge in the last permitted cycle still counts as a
                    // normal finish.
                    if (b_rise) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (gate_expired(gate_cnt)) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start = (state == ST_GATE);
    assign busy  = (state == ST_ARMED) || (state == ST_GATE);

endmodule

// File: doc/phase_gate_gen.md
Name: phase_gate_gen

Overview:
- Upstream stage of CLK_count: builds the `start` gate whose width in CLK cycles equals the delay from a rising edge of reference signal A to the next rising edge of signal B.
- CLK_count integrates that gate into Time, giving the A-to-B phase in clocks.
- Synchronises both asynchronous inputs, detects edges, runs a one-shot measurement FSM per arm request, and flags timeouts so a missing B edge cannot hold the gate open forever.

Parameters:
- CNT_W, 16, width of internal gate-length counter; matches Time width of CLK_count.
- MAX_GATE, 65535, maximum gate length in cycles before timeout; must be < 2^CNT_W.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- arm  input  1  level request to take one measurement; sampled in IDLE.
- sig_a  input  1  asynchronous reference signal A.
- sig_b  input  1  asynchronous measured signal B.
- start  output  1  gate to CLK_count; high exactly for the measured interval.
- done  output  1  one-cycle strobe: measurement finished (normal or timeout).
- timeout  output  1  sticky: last measurement hit MAX_GATE without a B edge.
- busy  output  1  high in ARMED or GATE.

Behaviour:
- Reset: synchronous, active-high, on the CLK edge where RST=1. State=IDLE; start=0, done=0, timeout=0, busy=0; synchroniser and edge registers cleared; gate counter=0. RST mid-GATE drops start on that same edge, and no done pulse follows.
- Synchronisers: each of sig_a and sig_b passes through 2 flops, then a third flop for edge detection. a_rise = s2 & ~s3 (likewise b_rise). Latency is identical on both channels, so the measured delta is unaffected.
- All outputs are registered; start and busy are decoded from the state register.
- IDLE: if arm=1, go to ARMED next cycle and clear timeout. Otherwise stay.
- ARMED:
  - a_rise=1 and b_rise=0: go to GATE; gate counter=0.
  - a_rise=1 and b_rise=1 in the same cycle: zero phase. Go to DONE; start never asserts.
  - b_rise alone: ignored.
  - arm dropping while ARMED does not abort.
- GATE:
  - start=1; gate counter increments each cycle.
  - b_rise=1: go to DONE.
  - Otherwise, counter == MAX_GATE-1: set timeout=1 and go to DONE.
  - a_rise while in GATE is ignored (no restart).
  - b_rise takes priority over timeout in the same cycle, and timeout stays 0.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Re-arm: if arm is still high, IDLE moves to ARMED on the following cycle, giving back-to-back measurements with a 2-cycle dead time (DONE, IDLE).
- Timing identity: if a_rise is seen in cycle n and b_rise in cycle m (m>n), start is high for cycles n+1..m, i.e. exactly m-n cycles. CLK_count therefore advances by m-n.
- Maximum gate length is MAX_GATE cycles.
- Gate counter never wraps, because MAX_GATE < 2^CNT_W is enforced by design rule.

Decomposition:
- Shared package: state encoding constants (IDLE=0, ARMED=1, GATE=2, DONE=3) and the default CNT_W, reused by CLK_count consumers and any result-capture stage.
- One sub-module is natural: edge_sync (2-flop synchroniser plus rising-edge detector, with CLK/RST). Instantiate it twice, for A and B.

Test Plan:
- Reset then idle: RST high 3 cycles with sig_a/sig_b toggling and arm=0 -> start, done, busy, timeout all stay 0.
- Nominal: arm=1; sig_a rises at cycle 10, sig_b rises at cycle 47 (both held high) -> start high exactly 37 cycles; done pulses once 1 cycle after start falls; timeout=0; downstream Time increments by 37.
- Simultaneous edges: sig_a and sig_b rise on the same cycle while ARMED -> start never asserts, done pulses once, timeout=0.
- Timeout: MAX_GATE=100, sig_a rises, sig_b held low -> start high exactly 100 cycles, timeout=1 with done. Next arm clears timeout one cycle after IDLE samples arm.
- B before A and extra A: sig_b rises at 5 (ignored), sig_a at 20 and again at 30, sig_b at 60 -> start high 40 cycles (from the first A only).
- Reset mid-gate: RST asserted 10 cycles into GATE -> start=0 on that edge, no done pulse; next arm plus edges 15 apart -> start high exactly 15 cycles.
